mem_addr_seq: RTL and testbench

- Parametrised successor to the memory-address selector of the multicycle MIPS datapath.
- Registers the memory address from one of three normal sources.
- Contains the exception-vector sequencer: on an exception it drives the vector byte address (VEC_BASE + code), waits MEM_LAT cycles, captures the handler byte from memory as the new PC, and latches the EPC.
- Sits between the control unit, PC/ALUOut registers and the memory address port.

---
 rtl/mem_addr_pkg.sv | 33 +++
 rtl/addr_src_mux.sv | 28 ++
 rtl/mem_addr_seq.sv | 122 ++++++++++++
 tb/tb_mem_addr_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_addr_pkg.sv
// rtl/mem_addr_pkg.sv - shared types and constants for the memory-address sequencer
package mem_addr_pkg;

  // Memory-address source selector encoding
  typedef enum logic [1:0] {
    SEL_JUMP = 2'd0,
    SEL_PC   = 2'd1,
    SEL_ALU  = 2'd2,
    SEL_RSVD = 2'd3
  } addr_sel_e;

  // Exception cause codes; each indexes one vector byte above the base
  typedef enum logic [1:0] {
    EXC_OPCODE = 2'd0,
    EXC_OVF    = 2'd1,
    EXC_DIV0   = 2'd2
  } exc_code_e;

  // Exception-vector sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  // Byte address of the vector for exception code 0
  localparam int VEC_BASE_DEFAULT = 253;

  // Width of the memory-latency wait counter (latency is 1..7)
  localparam int CNT_W = 3;

endpackage

// File: rtl/addr_src_mux.sv
// rtl/addr_src_mux.sv - combinational 4-way memory-address source select
module addr_src_mux
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int JADDR_W = 26
) (
  input  logic [1:0]         addr_sel,
  input  logic [JADDR_W-1:0] jaddr,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic [ADDR_W-1:0]  hold_addr,
  output logic [ADDR_W-1:0]  sel_addr
);

  // Pick the source; the jump field is zero-extended, the reserved code holds
  always_comb begin
    sel_addr = hold_addr;
    case (addr_sel_e'(addr_sel))
      SEL_JUMP: sel_addr = ADDR_W'(jaddr);
      SEL_PC:   sel_addr = pc_addr;
      SEL_ALU:  sel_addr = alu_addr;
      SEL_RSVD: sel_addr = hold_addr;
      default:  sel_addr = hold_addr;
    endcase
  end

endmodule

// File: rtl/mem_addr_seq.sv
// rtl/mem_addr_seq.sv - registered memory-address select with exception-vector sequencer
module mem_addr_seq
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int JADDR_W  = 26,
  parameter int MEM_LAT  = 1,
  parameter int VEC_BASE = VEC_BASE_DEFAULT,
  parameter int NUM_EXC  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         addr_sel,
  input  logic [JADDR_W-1:0] jaddr,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic               exc_req,
  input  logic [1:0]         exc_code,
  input  logic [ADDR_W-1:0]  epc_in,
  input  logic [7:0]         mem_byte,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               exc_busy,
  output logic               exc_done,
  output logic               exc_illegal,
  output logic [ADDR_W-1:0]  new_pc,
  output logic [ADDR_W-1:0]  epc_out
);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              illegal_q, illegal_d;

  logic [ADDR_W-1:0] mux_addr;
  logic              code_ok;

  addr_src_mux #(
    .ADDR_W  (ADDR_W),
    .JADDR_W (JADDR_W)
  ) u_addr_src_mux (
    .addr_sel  (addr_sel),
    .jaddr     (jaddr),
    .pc_addr   (pc_addr),
    .alu_addr  (alu_addr),
    .hold_addr (addr_q),
    .sel_addr  (mux_addr)
  );

  assign code_ok = (int'(exc_code) < NUM_EXC);

  // Next-state logic: normal address tracking in IDLE, vector fetch sequence otherwise
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    new_pc_d  = new_pc_q;
    epc_d     = epc_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (exc_req && code_ok) begin
          // Exception takes priority over any addr_sel update this cycle
          addr_d  = ADDR_W'(VEC_BASE) + ADDR_W'(exc_code);
          epc_d   = epc_in;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end else begin
          addr_d = mux_addr;
          if (exc_req) begin
            illegal_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        new_pc_d = ADDR_W'(mem_byte);
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      new_pc_q  <= '0;
      epc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      new_pc_q  <= new_pc_d;
      epc_q     <= epc_d;
      illegal_q <= illegal_d;
    end
  end

  assign addr_out    = addr_q;
  assign exc_busy    = (state_q != IDLE);
  assign exc_done    = (state_q == DONE);
  assign exc_illegal = illegal_q;
  assign new_pc      = new_pc_q;
  assign epc_out     = epc_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// tb/tb_mem_addr_seq.sv - directed self-checking bench for mem_addr_seq
module tb_mem_addr_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr_sel;
  logic [25:0] jaddr;
  logic [31:0] pc_addr;
  logic [31:0] alu_addr;
  logic        exc_req1;
  logic        exc_req3;
  logic [1:0]  exc_code;
  logic [31:0] epc_in;
  logic [7:0]  mem_byte;

  logic [31:0] addr1, new_pc1, epc1;
  logic        busy1, done1, ill1;
  logic [31:0] addr3, new_pc3, epc3;
  logic        busy3, done3, ill3;

  int tests = 0;
  int fails = 0;

  mem_addr_seq #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .addr_sel(addr_sel), .jaddr(jaddr),
    .pc_addr(pc_addr), .alu_addr(alu_addr), .exc_req(exc_req1),
    .exc_code(exc_code), .epc_in(epc_in), .mem_byte(mem_byte),
    .addr_out(addr1), .exc_busy(busy1), .exc_done(done1),
    .exc_illegal(ill1), .new_pc(new_pc1), .epc_out(epc1)
  );

  mem_addr_seq #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .addr_sel(addr_sel), .jaddr(jaddr),
    .pc_addr(pc_addr), .alu_addr(alu_addr), .exc_req(exc_req3),
    .exc_code(exc_code), .epc_in(epc_in), .mem_byte(mem_byte),
    .addr_out(addr3), .exc_busy(busy3), .exc_done(done3),
    .exc_illegal(ill3), .new_pc(new_pc3), .epc_out(epc3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    int done_at;

    reset_n  = 1'b0;
    addr_sel = 2'd1;
    jaddr    = '0;
    pc_addr  = '0;
    alu_addr = '0;
    exc_req1 = 1'b0;
    exc_req3 = 1'b0;
    exc_code = 2'd0;
    epc_in   = '0;
    mem_byte = '0;

    #3;
    chk("rst_addr",    addr1,  32'h0);
    chk("rst_busy",    {31'b0, busy1}, 32'h0);
    chk("rst_done",    {31'b0, done1}, 32'h0);
    chk("rst_illegal", {31'b0, ill1},  32'h0);
    chk("rst_new_pc",  new_pc1, 32'h0);
    chk("rst_epc",     epc1,    32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Normal source selection
    addr_sel = 2'd1; pc_addr = 32'h0000_0040;
    tick();
    chk("sel_pc",      addr1, 32'h0000_0040);
    chk("sel_pc_busy", {31'b0, busy1}, 32'h0);
    chk("sel_pc_done", {31'b0, done1}, 32'h0);

    addr_sel = 2'd0; jaddr = 26'h3FF_FFFF;
    tick();
    chk("sel_jump_zext", addr1, 32'h03FF_FFFF);

    addr_sel = 2'd3; pc_addr = 32'h0000_1234;
    tick();
    chk("sel_rsvd_hold", addr1, 32'h03FF_FFFF);

    addr_sel = 2'd2; alu_addr = 32'h8000_0004;
    tick();
    chk("sel_alu", addr1, 32'h8000_0004);

    // MEM_LAT=1 exception, code 1; addr_sel=1 in the same cycle must lose
    addr_sel = 2'd1; exc_req1 = 1'b1; exc_code = 2'd1;
    epc_in = 32'h0000_0100; mem_byte = 8'h8C;
    tick();
    exc_req1 = 1'b0;
    chk("l1_vec_addr", addr1, 32'd254);
    chk("l1_wait_busy", {31'b0, busy1}, 32'h1);
    chk("l1_wait_done", {31'b0, done1}, 32'h0);
    chk("l1_epc", epc1, 32'h0000_0100);
    tick();
    chk("l1_cap_done", {31'b0, done1}, 32'h0);
    chk("l1_cap_addr", addr1, 32'd254);
    tick();
    chk("l1_done_pulse", {31'b0, done1}, 32'h1);
    chk("l1_new_pc", new_pc1, 32'h0000_008C);
    chk("l1_done_epc", epc1, 32'h0000_0100);
    chk("l1_done_addr", addr1, 32'd254);
    tick();
    chk("l1_idle_done", {31'b0, done1}, 32'h0);
    chk("l1_idle_busy", {31'b0, busy1}, 32'h0);
    chk("l1_idle_addr_held", addr1, 32'd254);
    tick();
    chk("l1_resume_addr", addr1, 32'h0000_1234);
    chk("l1_new_pc_hold", new_pc1, 32'h0000_008C);

    // MEM_LAT=3 exception, code 2, request held into WAIT to test it is ignored
    exc_req3 = 1'b1; exc_code = 2'd2; epc_in = 32'h0000_0200; mem_byte = 8'h5A;
    tick();
    chk("l3_vec_addr", addr3, 32'd255);
    chk("l3_busy", {31'b0, busy3}, 32'h1);
    done_cnt = 0;
    done_at  = -1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 2) exc_req3 = 1'b0;
      tick();
      if (i <= 2) chk($sformatf("l3_wait_addr_%0d", i), addr3, 32'd255);
      if (done3) begin
        done_cnt++;
        done_at = i;
      end
    end
    exc_req3 = 1'b0;
    chk("l3_done_count", done_cnt, 32'd1);
    chk("l3_done_cycle", done_at, 32'd4);
    chk("l3_new_pc", new_pc3, 32'h0000_005A);
    chk("l3_epc", epc3, 32'h0000_0200);

    // Illegal code: sticky flag, no sequencing, normal select continues
    addr_sel = 2'd2; alu_addr = 32'h0000_0077; exc_req1 = 1'b1; exc_code = 2'd3;
    tick();
    exc_req1 = 1'b0;
    chk("ill_flag", {31'b0, ill1}, 32'h1);
    chk("ill_busy", {31'b0, busy1}, 32'h0);
    chk("ill_addr", addr1, 32'h0000_0077);
    alu_addr = 32'h0000_0088;
    tick();
    chk("ill_sticky", {31'b0, ill1}, 32'h1);
    chk("ill_addr_next", addr1, 32'h0000_0088);

    // Reset asserted mid-WAIT on the MEM_LAT=3 instance
    exc_req3 = 1'b1; exc_code = 2'd0; epc_in = 32'h0000_0300;
    tick();
    exc_req3 = 1'b0;
    chk("rw_vec_addr", addr3, 32'd253);
    chk("rw_epc", epc3, 32'h0000_0300);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_addr_zero", addr3, 32'h0);
    chk("rw_busy_zero", {31'b0, busy3}, 32'h0);
    chk("rw_epc_zero", epc3, 32'h0);
    chk("rw_new_pc_zero", new_pc3, 32'h0);
    chk("rw_illegal_cleared", {31'b0, ill1}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    addr_sel = 2'd1; pc_addr = 32'h0000_1234;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done3) done_cnt++;
    end
    chk("rw_no_done", done_cnt, 32'd0);
    chk("rw_idle_busy", {31'b0, busy3}, 32'h0);
    chk("rw_addr_follow", addr3, 32'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
